// File: rtl/hello_world_pkg.sv
// Shared types and helpers for the count_uart_tx transmitter.
// COUNT_UART_TX_PARITY_EN adds the PARITY state to the encoding.
package hello_world_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

`ifdef COUNT_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;
`endif

    // Clock cycles occupied by one frame, from the falling start edge to the end of the last stop bit.
    function automatic int unsigned frame_cycles(int unsigned clks_per_bit,
                                                 int unsigned stop_bits,
                                                 int unsigned parity);
        return (1 + UART_DATA_BITS + parity + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/count_uart_tx_baud_tick_gen.sv
// Baud-rate tick generator: a 0..CLKS_PER_BIT-1 counter whose wrap marks a bit boundary.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = (cnt_q == LastCnt);

    // Count up and wrap; clear realigns the count so the next bit gets a full period.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/count_uart_tx.sv
// UART transmitter for the free-running counter byte stream: start, 8 data bits LSB first,
// optional even parity (COUNT_UART_TX_PARITY_EN), then STOP_BITS stop bits.
module count_uart_tx
    import hello_world_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("count_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("count_uart_tx: CLKS_PER_BIT must be in 2..65535");
    end

    localparam logic [2:0] LastDataBit = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LastStopBit = 3'(STOP_BITS - 1);

    tx_state_t  state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       tx_q;
    logic       in_ready_q;
    logic       busy_q;
`ifdef COUNT_UART_TX_PARITY_EN
    logic       parity_q;
`endif

    logic handshake;
    logic tick;

    assign handshake = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(handshake),
        .tick (tick)
    );

    // Frame FSM with registered tx/in_ready/busy; bit_cnt_q is reused to count stop bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef COUNT_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q    <= START;
                        shift_q    <= in_data;
                        tx_q       <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef COUNT_UART_TX_PARITY_EN
                        parity_q   <= ^in_data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        // Wraps 7->0 on the last bit, leaving it ready for the stop count.
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LastDataBit) begin
`ifdef COUNT_UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end
                end
`ifdef COUNT_UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (bit_cnt_q == LastStopBit) begin
                            state_q    <= IDLE;
                            bit_cnt_q  <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_q       <= 1'b1;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_uart_tx.sv
// Self-checking bench for count_uart_tx with CLKS_PER_BIT=4; a second instance covers STOP_BITS=2.
module tb_count_uart_tx;

    localparam int CPB = 4;
`ifdef COUNT_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F1 = (1 + 8 + PAR + 1) * CPB;
    localparam int F2 = (1 + 8 + PAR + 2) * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, tx, busy;
    logic [7:0] in_data2 = 8'h00;
    logic       in_valid2 = 1'b0;
    logic       in_ready2, tx2, busy2;

    always #5 clk = ~clk;

    count_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy)
    );

    count_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data2),
        .in_valid(in_valid2),
        .in_ready(in_ready2),
        .tx      (tx2),
        .busy    (busy2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected line level c cycles after the handshake edge.
    function automatic logic exp_bit(input logic [7:0] b, input int c);
        int k;
        k = c / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Handshake log
    int cyc = 0;
    int hs_cnt = 0;
    int hs_t[32];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            hs_cnt <= hs_cnt + 1;
            if (hs_cnt < 32) hs_t[hs_cnt] <= cyc;
        end
    end

    // Scoreboard plus line monitor decoding frames at mid-bit
    logic [7:0] exp_q[$];
    bit mon_en = 1'b1;

    initial begin : monitor
        logic       prev;
        logic [7:0] d;
        logic [7:0] e;
        logic       st, pb, sb;
        prev = 1'b1;
        d = '0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = tx;
                end
                if (PAR == 1) begin
                    repeat (CPB) @(negedge clk);
                    pb = tx;
                end
                repeat (CPB) @(negedge clk);
                sb = tx;
                if (mon_en) begin
                    check("mon_start", {63'b0, st}, 64'd0);
                    check("mon_stop", {63'b0, sb}, 64'd1);
                    check("mon_queue_nonempty", {63'b0, exp_q.size() > 0}, 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("mon_data", {56'b0, d}, {56'b0, e});
                        if (PAR == 1) check("mon_parity", {63'b0, pb}, {63'b0, ^e});
                    end
                end
            end
            prev = tx;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {63'b0, in_ready}, 64'd1);
    endtask

    // Send one byte, then check the whole tx waveform and in_ready over the frame.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic [7:0] junk,
                              output logic [63:0] wave);
        logic [63:0] exp_w;
        int          ready_bad;
        @(negedge clk);
        wait_ready();
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = junk;
        exp_q.push_back(b);
        wave = '0;
        exp_w = '0;
        ready_bad = 0;
        for (int c = 0; c < F1; c++) begin
            @(negedge clk);
            wave[c]  = tx;
            exp_w[c] = exp_bit(b, c);
            if (in_ready !== 1'b0) ready_bad++;
        end
        check({tag, "_wave"}, wave, exp_w);
        check({tag, "_ready_low"}, 64'(ready_bad), 64'd0);
        @(negedge clk);
        check({tag, "_ready_after"}, {63'b0, in_ready}, 64'd1);
        check({tag, "_busy_after"}, {63'b0, busy}, 64'd0);
        check({tag, "_tx_idle"}, {63'b0, tx}, 64'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] w;
        logic [63:0] exp_w;
        int          h0, n, low, stop_hi;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx", {63'b0, tx}, 64'd1);
        check("rst_ready", {63'b0, in_ready}, 64'd1);
        check("rst_busy", {63'b0, busy}, 64'd0);

        // 0x55 frame
        send_frame("t1_55", 8'h55, 8'h00, w);

        // Back-to-back streaming: 0x00 then 0xFF with in_valid held
        @(negedge clk);
        h0 = hs_cnt;
        in_data  = 8'h00;
        in_valid = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        n = 0;
        while (hs_cnt < h0 + 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_data = 8'hFF;
        n = 0;
        while (hs_cnt < h0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        repeat (F1 + 10) @(negedge clk);
        check("t2_hs_count", 64'(hs_cnt - h0), 64'd2);
        if (hs_cnt >= h0 + 2)
            check("t2_period", 64'(hs_t[h0+1] - hs_t[h0]), 64'(F1 + 1));

        // in_data changes after handshake are ignored
        send_frame("t3_a5", 8'hA5, 8'h3C, w);

        // Mid-frame reset during data bit 3 of 0x0F, with in_valid high at the reset edge
        mon_en = 1'b0;
        @(negedge clk);
        wait_ready();
        in_data  = 8'h0F;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4 * CPB + 2) @(negedge clk);
        check("t4_in_bit3", {63'b0, tx}, 64'd1);
        check("t4_busy_mid", {63'b0, busy}, 64'd1);
        h0 = hs_cnt;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_tx_after_rst", {63'b0, tx}, 64'd1);
        check("t4_ready_after_rst", {63'b0, in_ready}, 64'd1);
        check("t4_busy_after_rst", {63'b0, busy}, 64'd0);
        check("t4_no_hs_in_rst", 64'(hs_cnt - h0), 64'd0);
        repeat (F1) @(negedge clk);
        check("t4_still_idle", {63'b0, tx}, 64'd1);
        mon_en = 1'b1;
        send_frame("t4_81", 8'h81, 8'h00, w);

`ifdef COUNT_UART_TX_PARITY_EN
        // Parity bit values
        send_frame("t5_07", 8'h07, 8'h00, w);
        check("t5_parity_07", {63'b0, w[9*CPB+2]}, 64'd1);
        send_frame("t5_03", 8'h03, 8'h00, w);
        check("t5_parity_03", {63'b0, w[9*CPB+2]}, 64'd0);
`endif

        // Two stop bits on the second instance
        @(negedge clk);
        check("t6_ready_pre", {63'b0, in_ready2}, 64'd1);
        in_data2  = 8'hF0;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        in_data2  = 8'h00;
        low = 0;
        stop_hi = 0;
        w = '0;
        exp_w = '0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (in_ready2 === 1'b1) break;
            if (low < 64) begin
                w[low]     = tx2;
                exp_w[low] = exp_bit(8'hF0, low);
            end
            if (low >= (9 + PAR) * CPB && tx2 === 1'b1) stop_hi++;
            low++;
            n++;
        end
        check("t6_ready_low_cycles", 64'(low), 64'(F2));
        check("t6_stop_high_cycles", 64'(stop_hi), 64'(2 * CPB));
        check("t6_wave", w, exp_w);

        repeat (F1 + 10) @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
